// File: rtl/mem_bridge_pkg.sv
// Shared types and default sizing for the CPU-to-memory bridge.
package mem_bridge_pkg;

    localparam int unsigned MB_DEPTH = 4;
    localparam int unsigned MB_AW    = 32;
    localparam int unsigned MB_DW    = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    typedef struct packed {
        logic [MB_AW-1:0] addr;
        logic [MB_DW-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write circular buffer with a newest-match address lookup for read forwarding.
module wbuf_fifo
    import mem_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = MB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wbuf_entry_t            push_entry,
    input  logic                   pop,
    output wbuf_entry_t            head_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c,
    input  logic [MB_AW-1:0]       lookup_addr,
    output logic                   hit_c,
    output logic [MB_DW-1:0]       hit_data_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wbuf_entry_t   buf_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] scan_idx;
    logic          do_push;
    logic          do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = buf_q[rd_ptr];

    // Pointers and occupancy; storage itself needs no reset since count gates validity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr] <= push_entry;
    end

    // Scan oldest to newest so the youngest matching entry wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (buf_q[scan_idx].addr == lookup_addr)) begin
                hit_c      = 1'b1;
                hit_data_c = buf_q[scan_idx].data;
            end
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// CPU memory-port bridge: posted writes, read forwarding, idle-time drains to a req/ack memory.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = MB_DEPTH,
    parameter int unsigned AW    = MB_AW,
    parameter int unsigned DW    = MB_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_rw,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ack,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] wbuf_count,
    output logic                   idle
);

    state_t      state;
    wbuf_entry_t push_entry;
    wbuf_entry_t head;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        hit;
    logic [MB_DW-1:0] hit_data;

    assign push_entry = '{addr: MB_AW'(cpu_addr), data: MB_DW'(cpu_wdata)};
    assign push       = (state == IDLE) && cpu_req && !cpu_rw && !full;
    assign pop        = (state == WR) && mem_ack;
    assign idle       = (state == IDLE) && empty && !cpu_req;

    wbuf_fifo #(.DEPTH(DEPTH)) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_c      (head),
        .count       (wbuf_count),
        .full_c      (full),
        .empty_c     (empty),
        .lookup_addr (MB_AW'(cpu_addr)),
        .hit_c       (hit),
        .hit_data_c  (hit_data)
    );

    // Request sequencing: read hit/miss first, then posted write, else drain the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && cpu_rw && hit) begin
                        cpu_rdata <= DW'(hit_data);
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else if (cpu_req && cpu_rw) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= '0;
                        state     <= RD;
                    end else if (cpu_req && !full) begin
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else if (!empty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= AW'(head.addr);
                        mem_wdata <= DW'(head.data);
                        state     <= WR;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= RESP;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: reset, posting, forwarding, miss priority, full buffer, spacing.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rw;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  wbuf_count;
    logic        idle;

    int compared   = 0;
    int mismatched = 0;

    mem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wbuf_count (wbuf_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a write and waits (bounded) for its cpu_ready; returns in the pulse cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output bit got);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick;
            if (cpu_ready === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_mem_req got=%0h want=0", mem_req); end
        compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cpu_ready got=%0h want=0", cpu_ready); end
        compared++; if (wbuf_count !== 3'd0) begin mismatched++; $display("FAIL rst_count got=%0d want=0", wbuf_count); end
        compared++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0 || mem_we !== 1'b0) begin
            mismatched++; $display("FAIL rst_busses addr=%0h wdata=%0h rdata=%0h we=%0h want all 0", mem_addr, mem_wdata, cpu_rdata, mem_we); end
        tick; reset = 1'b1; tick;
        compared++; if (idle !== 1'b1) begin mismatched++; $display("FAIL rst_idle got=%0h want=1", idle); end
        // Read miss, then reset while the request is outstanding.
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h40;
        tick;
        compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin mismatched++; $display("FAIL rst_rd_req req=%0h addr=%0h want 1/40", mem_req, mem_addr); end
        #2 reset = 1'b0;
        #1;
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_async_drop got=%0h want=0", mem_req); end
        cpu_req = 1'b0;
        tick; reset = 1'b1; tick;
        compared++; if (idle !== 1'b1 || wbuf_count !== 3'd0 || mem_req !== 1'b0) begin
            mismatched++; $display("FAIL rst_release idle=%0h count=%0d req=%0h want 1/0/0", idle, wbuf_count, mem_req); end
    endtask

    task automatic test_posted_write;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        tick;
        compared++; if (cpu_ready !== 1'b1 || wbuf_count !== 3'd1) begin mismatched++; $display("FAIL pw_ready ready=%0h count=%0d want 1/1", cpu_ready, wbuf_count); end
        cpu_req = 1'b0;
        tick;
        compared++; if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin mismatched++; $display("FAIL pw_pulse ready=%0h req=%0h want 0/0", cpu_ready, mem_req); end
        tick;
        compared++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            mismatched++; $display("FAIL pw_drain req=%0h we=%0h addr=%0h data=%0h want 1/1/10/deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
        tick; tick;
        compared++; if (mem_req !== 1'b1 || wbuf_count !== 3'd1) begin mismatched++; $display("FAIL pw_hold req=%0h count=%0d want 1/1", mem_req, wbuf_count); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (mem_req !== 1'b0 || wbuf_count !== 3'd0) begin mismatched++; $display("FAIL pw_pop req=%0h count=%0d want 0/0", mem_req, wbuf_count); end
        tick;
        compared++; if (idle !== 1'b1) begin mismatched++; $display("FAIL pw_idle got=%0h want=1", idle); end
    endtask

    task automatic test_forwarding;
        bit got;
        do_write(32'h20, 32'h1, got);
        compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL fw_wr1 ready_seen=%0b want=1", got); end
        do_write(32'h20, 32'h2, got);
        compared++; if (got !== 1'b1 || wbuf_count !== 3'd2) begin mismatched++; $display("FAIL fw_wr2 seen=%0b count=%0d want 1/2", got, wbuf_count); end
        cpu_rw = 1'b1; cpu_addr = 32'h20;
        tick;
        compared++; if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin mismatched++; $display("FAIL fw_gap ready=%0h req=%0h want 0/0", cpu_ready, mem_req); end
        tick;
        compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h2 || mem_req !== 1'b0) begin
            mismatched++; $display("FAIL fw_hit ready=%0h rdata=%0h req=%0h want 1/2/0", cpu_ready, cpu_rdata, mem_req); end
        cpu_req = 1'b0;
        tick; tick;
        compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1) begin
            mismatched++; $display("FAIL fw_drain1 req=%0h addr=%0h data=%0h want 1/20/1", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (mem_req !== 1'b0 || wbuf_count !== 3'd1) begin mismatched++; $display("FAIL fw_pop1 req=%0h count=%0d want 0/1", mem_req, wbuf_count); end
        tick;
        compared++; if (mem_req !== 1'b1 || mem_wdata !== 32'h2) begin mismatched++; $display("FAIL fw_drain2 req=%0h data=%0h want 1/2", mem_req, mem_wdata); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (wbuf_count !== 3'd0) begin mismatched++; $display("FAIL fw_empty count=%0d want=0", wbuf_count); end
        tick;
    endtask

    task automatic test_read_miss_priority;
        bit got;
        do_write(32'h50, 32'hA, got);
        do_write(32'h54, 32'hB, got);
        compared++; if (got !== 1'b1 || wbuf_count !== 3'd2) begin mismatched++; $display("FAIL rm_fill seen=%0b count=%0d want 1/2", got, wbuf_count); end
        cpu_rw = 1'b1; cpu_addr = 32'h30; mem_rdata = 32'hCAFE0001;
        tick;
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rm_gap req=%0h want=0", mem_req); end
        tick;
        compared++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h30 || mem_wdata !== 32'h0) begin
            mismatched++; $display("FAIL rm_req req=%0h we=%0h addr=%0h wdata=%0h want 1/0/30/0", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hCAFE0001 || mem_req !== 1'b0) begin
            mismatched++; $display("FAIL rm_resp ready=%0h rdata=%0h req=%0h want 1/cafe0001/0", cpu_ready, cpu_rdata, mem_req); end
        cpu_req = 1'b0;
        tick; tick;
        compared++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h50 || mem_wdata !== 32'hA) begin
            mismatched++; $display("FAIL rm_drain1 req=%0h we=%0h addr=%0h data=%0h want 1/1/50/a", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        tick;
        compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h54 || mem_wdata !== 32'hB) begin
            mismatched++; $display("FAIL rm_drain2 req=%0h addr=%0h data=%0h want 1/54/b", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (wbuf_count !== 3'd0) begin mismatched++; $display("FAIL rm_empty count=%0d want=0", wbuf_count); end
        tick;
    endtask

    task automatic test_full_buffer;
        bit got;
        for (int k = 0; k < 4; k++) begin
            do_write(32'h100 + 32'(k), 32'h11 + 32'(k), got);
            compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL full_fill%0d seen=%0b want=1", k, got); end
        end
        compared++; if (wbuf_count !== 3'd4) begin mismatched++; $display("FAIL full_count got=%0d want=4", wbuf_count); end
        cpu_addr = 32'h104; cpu_wdata = 32'h15;
        tick; tick;
        compared++; if (cpu_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin
            mismatched++; $display("FAIL full_drain ready=%0h req=%0h we=%0h addr=%0h want 0/1/1/100", cpu_ready, mem_req, mem_we, mem_addr); end
        tick; tick;
        compared++; if (cpu_ready !== 1'b0 || wbuf_count !== 3'd4) begin mismatched++; $display("FAIL full_wait ready=%0h count=%0d want 0/4", cpu_ready, wbuf_count); end
        mem_ack = 1'b1; tick; mem_ack = 1'b0;
        compared++; if (cpu_ready !== 1'b0 || wbuf_count !== 3'd3) begin mismatched++; $display("FAIL full_pop ready=%0h count=%0d want 0/3", cpu_ready, wbuf_count); end
        tick;
        compared++; if (cpu_ready !== 1'b1 || wbuf_count !== 3'd4) begin mismatched++; $display("FAIL full_accept ready=%0h count=%0d want 1/4", cpu_ready, wbuf_count); end
        cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic prev;
        int   n;
        n = 0; prev = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            compared++; if (prev === 1'b1 && mem_req === 1'b1) begin mismatched++; $display("FAIL b2b_spacing cycle=%0d req=%0h want 0 after a req cycle", i, mem_req); end
            if (mem_req === 1'b1) begin
                if (n < 4) begin
                    compared++; if (mem_addr !== 32'h101 + 32'(n) || mem_wdata !== 32'h12 + 32'(n) || mem_we !== 1'b1) begin
                        mismatched++; $display("FAIL b2b_order%0d addr=%0h data=%0h we=%0h want %0h/%0h/1", n, mem_addr, mem_wdata, mem_we, 32'h101 + 32'(n), 32'h12 + 32'(n)); end
                end
                n++;
            end
            prev = mem_req;
        end
        mem_ack = 1'b0;
        compared++; if (n !== 4) begin mismatched++; $display("FAIL b2b_count drains=%0d want=4", n); end
        compared++; if (wbuf_count !== 3'd0 || idle !== 1'b1) begin mismatched++; $display("FAIL b2b_final count=%0d idle=%0h want 0/1", wbuf_count, idle); end
    endtask

    initial begin
        test_reset;
        test_posted_write;
        test_forwarding;
        test_read_miss_priority;
        test_full_buffer;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
